// File: rtl/pll_lock_supervisor.sv
// Supervises PLL reset and lock acquisition. Holds the decoder in reset until the
// lock has been stable, and retries automatically after a timeout or a filtered loss of lock.
module pll_lock_supervisor #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 50000,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned LOSS_FILTER   = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             pll_locked,
  input  logic             clear_err,
  output logic             pll_rst,
  output logic             dec_rst,
  output logic             ready,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] relock_count,
  output logic             timeout_err
);

  localparam int unsigned MAX_AB    = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MAX_ALL   = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int unsigned CNT_BITS  = (MAX_ALL < 2) ? 1 : $clog2(MAX_ALL);
  localparam int unsigned LOSS_BITS = $clog2(LOSS_FILTER + 1);

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABILIZE = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t               st;
  state_t               st_nx;
  logic                 sync1;
  logic                 locked_s;
  logic [CNT_BITS-1:0]  cnt;
  logic [LOSS_BITS-1:0] loss_cnt;
  logic                 ev_timeout;
  logic                 ev_relock;

  assign state = st;

  always_comb begin
    st_nx      = st;
    ev_timeout = 1'b0;
    ev_relock  = 1'b0;
    case (st)
      PLL_RST: begin
        if (cnt == CNT_BITS'(RST_CYCLES - 1)) st_nx = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          st_nx = STABILIZE;
        end else if (cnt == CNT_BITS'(LOCK_TIMEOUT - 1)) begin
          st_nx      = PLL_RST;
          ev_timeout = 1'b1;
          ev_relock  = 1'b1;
        end
      end
      STABILIZE: begin
        if (!locked_s) begin
          st_nx = WAIT_LOCK;
        end else if (cnt == CNT_BITS'(STABLE_CYCLES - 1)) begin
          st_nx = RUN;
        end
      end
      RUN: begin
        // The current low sample is the LOSS_FILTER-th when loss_cnt already holds LOSS_FILTER-1.
        if (!locked_s && (loss_cnt == LOSS_BITS'(LOSS_FILTER - 1))) begin
          st_nx     = PLL_RST;
          ev_relock = 1'b1;
        end
      end
      default: st_nx = PLL_RST;
    endcase
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      sync1        <= 1'b0;
      locked_s     <= 1'b0;
      st           <= PLL_RST;
      cnt          <= '0;
      loss_cnt     <= '0;
      pll_rst      <= 1'b1;
      dec_rst      <= 1'b1;
      ready        <= 1'b0;
      relock_count <= '0;
      timeout_err  <= 1'b0;
    end else begin
      sync1    <= pll_locked;
      locked_s <= sync1;
      st       <= st_nx;
      pll_rst  <= (st_nx == PLL_RST);
      ready    <= (st_nx == RUN);
      dec_rst  <= (st_nx != RUN);

      if (st_nx != st) begin
        cnt      <= '0;
        loss_cnt <= '0;
      end else if (st == RUN) begin
        loss_cnt <= locked_s ? '0 : loss_cnt + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      // A set/increment event in the same cycle as clear_err takes priority over the clear.
      if (ev_timeout)     timeout_err <= 1'b1;
      else if (clear_err) timeout_err <= 1'b0;

      if (ev_relock) begin
        if (clear_err)          relock_count <= CNT_W'(1);
        else if (!(&relock_count)) relock_count <= relock_count + 1'b1;
      end else if (clear_err) begin
        relock_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor: bring-up, timeout, glitch filter,
// stabilize abort, clear/saturation and mid-run reset, with hand-computed edge timing.
module tb_pll_lock_supervisor;

  localparam int unsigned RST_CYCLES    = 4;
  localparam int unsigned LOCK_TIMEOUT  = 100;
  localparam int unsigned STABLE_CYCLES = 8;
  localparam int unsigned LOSS_FILTER   = 3;
  localparam int unsigned CNT_W         = 4;

  logic             refclk = 1'b0;
  logic             rst;
  logic             pll_locked;
  logic             clear_err;
  logic             pll_rst;
  logic             dec_rst;
  logic             ready;
  logic [1:0]       state;
  logic [CNT_W-1:0] relock_count;
  logic             timeout_err;

  int n_cmp = 0;
  int n_err = 0;

  pll_lock_supervisor #(
    .RST_CYCLES   (RST_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .STABLE_CYCLES(STABLE_CYCLES),
    .LOSS_FILTER  (LOSS_FILTER),
    .CNT_W        (CNT_W)
  ) dut (
    .refclk      (refclk),
    .rst         (rst),
    .pll_locked  (pll_locked),
    .clear_err   (clear_err),
    .pll_rst     (pll_rst),
    .dec_rst     (dec_rst),
    .ready       (ready),
    .state       (state),
    .relock_count(relock_count),
    .timeout_err (timeout_err)
  );

  always #10 refclk = ~refclk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges; outputs are sampled 1 ns after the last edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge refclk);
      #1;
    end
  endtask

  initial begin
    rst        = 1'b1;
    pll_locked = 1'b0;
    clear_err  = 1'b0;
    tick(3);
    check_eq("rst_state",   32'(state), 0);
    check_eq("rst_pll_rst", 32'(pll_rst), 1);
    check_eq("rst_dec_rst", 32'(dec_rst), 1);
    check_eq("rst_ready",   32'(ready), 0);
    check_eq("rst_relock",  32'(relock_count), 0);
    check_eq("rst_tmo",     32'(timeout_err), 0);

    // 1: nominal bring-up, lock first sampled at edge 14
    rst = 1'b0;
    tick(3);
    check_eq("t1_prst_e3", 32'(pll_rst), 1);
    tick(1);
    check_eq("t1_prst_e4",  32'(pll_rst), 0);
    check_eq("t1_state_e4", 32'(state), 1);
    tick(9);
    pll_locked = 1'b1;
    tick(2);
    check_eq("t1_state_e15", 32'(state), 1);
    tick(1);
    check_eq("t1_state_e16", 32'(state), 2);
    tick(7);
    check_eq("t1_state_e23", 32'(state), 2);
    check_eq("t1_ready_e23", 32'(ready), 0);
    tick(1);
    check_eq("t1_state_e24", 32'(state), 3);
    check_eq("t1_ready_e24", 32'(ready), 1);
    check_eq("t1_decrst_e24", 32'(dec_rst), 0);
    check_eq("t1_relock", 32'(relock_count), 0);

    // 3: glitch filter - 2-cycle drop ignored, 3-cycle drop forces relock
    pll_locked = 1'b0;
    tick(2);
    pll_locked = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      check_eq("t3_glitch_ready", 32'(ready), 1);
    end
    check_eq("t3_glitch_relock", 32'(relock_count), 0);
    pll_locked = 1'b0;
    tick(4);
    check_eq("t3_state_L3", 32'(state), 3);
    tick(1);
    check_eq("t3_state_L4",  32'(state), 0);
    check_eq("t3_prst_L4",   32'(pll_rst), 1);
    check_eq("t3_decrst_L4", 32'(dec_rst), 1);
    check_eq("t3_ready_L4",  32'(ready), 0);
    check_eq("t3_relock",    32'(relock_count), 1);
    check_eq("t3_tmo",       32'(timeout_err), 0);

    // 4: stabilize abort at cnt=5, then 8 fresh stable cycles
    tick(4);
    check_eq("t4_wait", 32'(state), 1);
    pll_locked = 1'b1;
    tick(6);
    check_eq("t4_stab_E5", 32'(state), 2);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    tick(1);
    check_eq("t4_state_E7", 32'(state), 2);
    tick(1);
    check_eq("t4_state_E8", 32'(state), 1);
    tick(1);
    check_eq("t4_state_E9", 32'(state), 2);
    tick(1);
    check_eq("t4_state_E10", 32'(state), 2);
    tick(6);
    check_eq("t4_state_E16", 32'(state), 2);
    check_eq("t4_ready_E16", 32'(ready), 0);
    tick(1);
    check_eq("t4_state_E17", 32'(state), 3);
    check_eq("t4_ready_E17", 32'(ready), 1);
    check_eq("t4_relock",    32'(relock_count), 1);

    // 6: one-cycle reset in RUN
    rst = 1'b1;
    pll_locked = 1'b0;
    tick(1);
    check_eq("t6_state",   32'(state), 0);
    check_eq("t6_prst",    32'(pll_rst), 1);
    check_eq("t6_decrst",  32'(dec_rst), 1);
    check_eq("t6_ready",   32'(ready), 0);
    check_eq("t6_relock",  32'(relock_count), 0);
    check_eq("t6_tmo",     32'(timeout_err), 0);
    rst = 1'b0;

    // 2: lock timeout with locked held low
    tick(103);
    check_eq("t2_state_e103", 32'(state), 1);
    check_eq("t2_tmo_e103",   32'(timeout_err), 0);
    tick(1);
    check_eq("t2_state_e104",  32'(state), 0);
    check_eq("t2_tmo_e104",    32'(timeout_err), 1);
    check_eq("t2_relock_e104", 32'(relock_count), 1);
    check_eq("t2_prst_e104",   32'(pll_rst), 1);
    tick(3);
    check_eq("t2_prst_e107", 32'(pll_rst), 1);
    tick(1);
    check_eq("t2_prst_e108",  32'(pll_rst), 0);
    check_eq("t2_state_e108", 32'(state), 1);

    // 5: saturation over 16 timeouts (every 104 edges), then clear behaviour
    tick(100);
    check_eq("t5_relock_k2", 32'(relock_count), 2);
    for (int k = 3; k <= 16; k++) begin
      tick(104);
      check_eq("t5_relock_sat", 32'(relock_count), (k < 15) ? k : 15);
      check_eq("t5_state_tmo",  32'(state), 0);
    end
    clear_err = 1'b1;
    tick(1);
    clear_err = 1'b0;
    check_eq("t5_clr_relock", 32'(relock_count), 0);
    check_eq("t5_clr_tmo",    32'(timeout_err), 0);
    tick(102);
    check_eq("t5_pre_state", 32'(state), 1);
    check_eq("t5_pre_tmo",   32'(timeout_err), 0);
    clear_err = 1'b1;
    tick(1);
    clear_err = 1'b0;
    check_eq("t5_coinc_tmo",    32'(timeout_err), 1);
    check_eq("t5_coinc_relock", 32'(relock_count), 1);
    check_eq("t5_coinc_state",  32'(state), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Sequences the reset and lock acquisition of the 14.318181 MHz decoder-clock PLL and gates the downstream decoder reset on a stable lock. Runs on the 50 MHz reference clock. Drives the PLL `rst` input and samples its asynchronous `locked` output. Holds the TVP5147M1 interface logic in reset until lock has been continuously stable, and re-acquires lock automatically after a timeout or a filtered loss of lock.

## Interface
- `RST_CYCLES`, 16: width of the PLL reset pulse, in refclk cycles (≥1).
- `LOCK_TIMEOUT`, 50000: refclk cycles allowed in WAIT_LOCK before a retry (≥1; 1 ms at 50 MHz).
- `STABLE_CYCLES`, 1024: consecutive locked cycles required before release (≥1).
- `LOSS_FILTER`, 4: consecutive unlocked cycles in RUN that count as loss of lock (≥1).
- `CNT_W`, 8: width of `relock_count`.
- `refclk` in 1: 50 MHz clock; all logic is clocked on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `pll_locked` in 1: PLL `locked` output; asynchronous to `refclk`.
- `clear_err` in 1: single-cycle pulse that clears `timeout_err` and `relock_count`.
- `pll_rst` out 1: drives the PLL `rst` input.
- `dec_rst` out 1: active-high reset for the decoder logic. The consumer re-synchronizes it into the 14.318 MHz domain.
- `ready` out 1: high only in RUN.
- `state` out 2: current state; 0 PLL_RST, 1 WAIT_LOCK, 2 STABILIZE, 3 RUN.
- `relock_count` out CNT_W: number of automatic re-entries into PLL_RST; saturates at all-ones.
- `timeout_err` out 1: sticky; set when a lock timeout occurs.

## Operation
- **Lock synchronizer:** `pll_locked` passes through 2 flops to give `locked_s`. The FSM sees `locked_s` only.
- **Moore outputs**, decoded from the state register:
  - `pll_rst` = (state==PLL_RST)
  - `ready` = (state==RUN)
  - `dec_rst` = (state!=RUN)
- **Shared counter:** one cycle counter `cnt` is used by all states. Its width is clog2 of max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES). It is cleared on every state change.
- **PLL_RST:** `cnt` increments each cycle. At the edge where `cnt`==RST_CYCLES-1, go to WAIT_LOCK.
- **WAIT_LOCK:**
  - If `locked_s`=1, go to STABILIZE.
  - Else, at the edge where `cnt`==LOCK_TIMEOUT-1: go to PLL_RST, set `timeout_err`, increment `relock_count`.
- **STABILIZE:**
  - If `locked_s`=0, go to WAIT_LOCK. The timeout restarts from 0.
  - Else, at the edge where `cnt`==STABLE_CYCLES-1, go to RUN.
- **RUN:**
  - `loss_cnt` increments while `locked_s`=0 and clears when `locked_s`=1.
  - On the edge where the LOSS_FILTER-th consecutive low sample is taken: go to PLL_RST and increment `relock_count`.
  - A low run shorter than LOSS_FILTER has no effect; `ready` stays 1.
- **clear_err:** clears `timeout_err` and `relock_count` to 0. If a set or increment occurs in the same cycle, that event wins: `timeout_err`=1 and `relock_count`=1.
- **relock_count saturation:** at all-ones the count holds.
- **Reset values while `rst`=1:**
  - state=PLL_RST, `cnt`=0, `loss_cnt`=0, sync flops=0.
  - `pll_rst`=1, `dec_rst`=1, `ready`=0.
  - `relock_count`=0, `timeout_err`=0.
- **Reset mid-operation:** `rst` from any state returns to the values above on the next edge. A forced reset is not counted in `relock_count`.

## Timing
- Edge numbering: edge 1 is the first rising edge with `rst`=0.
- **PLL reset pulse:** `pll_rst` stays high through edge RST_CYCLES and is low after it.
- **Lock to release:** let edge E be the first edge at which `pll_locked`=1 is sampled, with the FSM in WAIT_LOCK.
  - `locked_s`=1 after E+1.
  - STABILIZE after E+2.
  - RUN (`ready`=1, `dec_rst`=0) after E+2+STABLE_CYCLES.
- **Loss of lock:** let L be the first edge at which `pll_locked`=0 is sampled in RUN.
  - PLL_RST after L+1+LOSS_FILTER.
  - At that same edge `dec_rst`=1, `ready`=0, `pll_rst`=1.
- **Timeout:** `timeout_err` rises on the same edge as the WAIT_LOCK→PLL_RST transition.
- **Throughput:** no combinational path from inputs to outputs.

## Test plan
All scenarios use RST_CYCLES=4, LOCK_TIMEOUT=100, STABLE_CYCLES=8, LOSS_FILTER=3, CNT_W=4. The PLL model drops `locked` while `pll_rst`=1 and raises it a chosen number of cycles after `pll_rst` falls.

1. **Nominal bring-up:** lock rises so it is first sampled at edge 14 -> `pll_rst` low after edge 4; state=2 after edge 16; `ready`=1 after edge 24; `relock_count`=0.
2. **Lock timeout:** `locked` held low -> after edge 104, `state`=0, `timeout_err`=1, `relock_count`=1. A second `pll_rst` pulse lasts 4 cycles.
3. **Glitch filter:** in RUN, drop `pll_locked` for 2 cycles -> `ready` stays 1 and `relock_count` is unchanged. Drop it for 3 cycles -> PLL_RST 4 edges after the first low sample, and `relock_count`=1.
4. **Stabilize abort:** drop lock for 1 cycle at STABILIZE `cnt`=5 -> return to WAIT_LOCK. RUN is reached only after 8 fresh stable cycles.
5. **Clear and saturation:** force 16 timeouts -> `relock_count`=15 (holds). `clear_err` alone -> both fields 0. `clear_err` coincident with a timeout edge -> `timeout_err`=1, `relock_count`=1.
6. **Reset mid-RUN:** assert `rst` for 1 cycle in RUN -> next edge `state`=0, `pll_rst`=1, `dec_rst`=1, `relock_count`=0, `timeout_err`=0.
